// File: rtl/imm_gen_pkg.sv
// Shared constants for the registered immediate generator: instruction width,
// immediate format select codes and FSM state encoding.
package imm_gen_pkg;

    localparam int ILEN = 32;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;
    localparam logic [2:0] IMM_Z = 3'b101;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_LOADED = 2'd1,
        ST_READY  = 2'd2
    } state_t;

endpackage

// File: rtl/imm_gen_seq_decode.sv
// Combinational RISC-V immediate extraction and sign extension to XLEN.
// Optional macro IMM_GEN_CSR_EN enables the Z (CSR zimm) format on select 101.
import imm_gen_pkg::*;

module imm_decode #(
    parameter int XLEN = 32
) (
    input  logic [ILEN-1:0] i_ir,
    input  logic [2:0]      i_imm_sel,
    output logic [XLEN-1:0] o_imm,
    output logic            o_illegal
);

    logic [31:0] w_imm32;
    logic        w_unused_opcode;

    // The opcode field never contributes to any immediate.
    assign w_unused_opcode = ^i_ir[6:0];

    always_comb begin
        w_imm32   = '0;
        o_illegal = 1'b0;
        case (i_imm_sel)
            IMM_I: w_imm32 = {{20{i_ir[31]}}, i_ir[31:20]};
            IMM_S: w_imm32 = {{20{i_ir[31]}}, i_ir[31:25], i_ir[11:7]};
            IMM_B: w_imm32 = {{19{i_ir[31]}}, i_ir[31], i_ir[7], i_ir[30:25],
                              i_ir[11:8], 1'b0};
            IMM_U: w_imm32 = {i_ir[31:12], 12'b0};
            IMM_J: w_imm32 = {{11{i_ir[31]}}, i_ir[31], i_ir[19:12], i_ir[20],
                              i_ir[30:21], 1'b0};
`ifdef IMM_GEN_CSR_EN
            IMM_Z: w_imm32 = {27'b0, i_ir[19:15]};
`endif
            default: o_illegal = 1'b1;
        endcase
    end

    // Every 32-bit result already carries its sign in bit 31 (Z has a zero there).
    assign o_imm = XLEN'($signed(w_imm32));

endmodule

// File: rtl/imm_gen_seq.sv
// Registered immediate generator: instruction register, 3-state FSM and output
// registers around imm_decode. Optional macro IMM_GEN_CSR_EN (see imm_decode).
import imm_gen_pkg::*;

module imm_gen_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] bus_in,
    input  logic            ld_ir,
    input  logic [2:0]      imm_sel,
    input  logic            en_imm,
    output logic [XLEN-1:0] imm_out,
    output logic            imm_valid,
    output logic            bus_drive,
    output logic [31:0]     ir_out,
    output logic            illegal_sel
);

    state_t            r_state;
    state_t            w_next_state;
    logic [ILEN-1:0]   r_ir;
    logic [XLEN-1:0]   r_imm;
    logic              r_illegal;
    logic [2:0]        r_sel_q;
    logic [XLEN-1:0]   w_imm;
    logic              w_illegal;
    logic              w_imm_valid;
    logic              w_capture;
    logic              w_unused_bus;

    assign w_unused_bus = ^bus_in;

    imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .i_ir      (r_ir),
        .i_imm_sel (imm_sel),
        .o_imm     (w_imm),
        .o_illegal (w_illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_EMPTY:  w_next_state = ld_ir ? ST_LOADED : ST_EMPTY;
            ST_LOADED: w_next_state = ld_ir ? ST_LOADED : ST_READY;
            ST_READY:  w_next_state = (ld_ir || (imm_sel != r_sel_q)) ? ST_LOADED : ST_READY;
            default:   w_next_state = ST_EMPTY;
        endcase
    end

    // A select change in READY invalidates the output in the same cycle.
    always_comb begin
        w_imm_valid = (r_state == ST_READY) && (imm_sel == r_sel_q);
    end

    // A reload while LOADED restarts the wait, so no decode is captured then.
    assign w_capture = (r_state == ST_LOADED) && !ld_ir;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ir      <= '0;
            r_imm     <= '0;
            r_illegal <= 1'b0;
            r_sel_q   <= IMM_I;
        end else begin
            if (ld_ir) begin
                r_ir <= bus_in[ILEN-1:0];
            end
            if (w_capture) begin
                r_imm     <= w_illegal ? '0 : w_imm;
                r_illegal <= w_illegal;
                r_sel_q   <= imm_sel;
            end
        end
    end

    assign imm_out     = r_imm;
    assign imm_valid   = w_imm_valid;
    assign bus_drive   = en_imm & w_imm_valid;
    assign ir_out      = r_ir;
    assign illegal_sel = r_illegal;

endmodule

// File: tb/tb_imm_gen_seq.sv
// Directed bench for imm_gen_seq: XLEN=32 and XLEN=64 instances share stimulus.
module tb_imm_gen_seq;
    import imm_gen_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] bus64;
    logic [31:0] bus32;
    logic        ld_ir;
    logic [2:0]  imm_sel;
    logic        en_imm;

    logic [31:0] imm32, ir32;
    logic        valid32, drive32, ill32;
    logic [63:0] imm64;
    logic [31:0] ir64;
    logic        valid64, drive64, ill64;

    int errors = 0;
    int checks = 0;

    assign bus32 = bus64[31:0];

    always #5 clk = ~clk;

    imm_gen_seq #(.XLEN(32)) u_dut32 (
        .clk(clk), .rst(rst), .bus_in(bus32), .ld_ir(ld_ir), .imm_sel(imm_sel),
        .en_imm(en_imm), .imm_out(imm32), .imm_valid(valid32), .bus_drive(drive32),
        .ir_out(ir32), .illegal_sel(ill32)
    );

    imm_gen_seq #(.XLEN(64)) u_dut64 (
        .clk(clk), .rst(rst), .bus_in(bus64), .ld_ir(ld_ir), .imm_sel(imm_sel),
        .en_imm(en_imm), .imm_out(imm64), .imm_valid(valid64), .bus_drive(drive64),
        .ir_out(ir64), .illegal_sel(ill64)
    );

    typedef struct {
        string       name;
        logic [31:0] ir;
        logic [2:0]  sel;
        logic [31:0] imm;
        logic        ill;
    } vec_t;

    vec_t vecs[$];

`ifdef IMM_GEN_CSR_EN
    localparam logic [31:0] Z_IMM = 32'd31;
    localparam logic        Z_ILL = 1'b0;
`else
    localparam logic [31:0] Z_IMM = 32'd0;
    localparam logic        Z_ILL = 1'b1;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] sext(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    task automatic load_ir(input logic [31:0] ir, input logic [2:0] sel);
        bus64   = {32'hA5A5_5A5A, ir};
        imm_sel = sel;
        ld_ir   = 1'b1;
        step();
        ld_ir = 1'b0;
        step();
    endtask

    task automatic apply(input vec_t v);
        bus64   = {32'hDEAD_BEEF, v.ir};
        imm_sel = v.sel;
        ld_ir   = 1'b1;
        en_imm  = 1'b0;
        step();
        ld_ir = 1'b0;
        #1;
        chk({v.name, " ir_out"}, {32'h0, ir32}, {32'h0, v.ir});
        chk({v.name, " ir_out64"}, {32'h0, ir64}, {32'h0, v.ir});
        chk({v.name, " valid_loaded"}, {63'h0, valid32}, 64'h0);
        step();
        chk({v.name, " imm32"}, {32'h0, imm32}, {32'h0, v.imm});
        chk({v.name, " imm64"}, imm64, sext(v.imm));
        chk({v.name, " valid"}, {62'h0, valid64, valid32}, 64'h3);
        chk({v.name, " illegal"}, {62'h0, ill64, ill32}, {62'h0, v.ill, v.ill});
        en_imm = 1'b1;
        #1;
        chk({v.name, " bus_drive"}, {62'h0, drive64, drive32}, 64'h3);
        en_imm = 1'b0;
    endtask

    initial begin
        vecs.push_back('{"I_neg",   32'hFFF00093, IMM_I, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{"I_pos",   32'h7FF00093, IMM_I, 32'h0000_07FF, 1'b0});
        vecs.push_back('{"S_pos",   32'h00A12423, IMM_S, 32'h0000_0008, 1'b0});
        vecs.push_back('{"S_neg",   32'hFE112E23, IMM_S, 32'hFFFF_FFFC, 1'b0});
        vecs.push_back('{"B_neg4",  32'hFE000EE3, IMM_B, 32'hFFFF_FFFC, 1'b0});
        vecs.push_back('{"B_neg",   32'hFE000E63, IMM_B, 32'hFFFF_F7FC, 1'b0});
        vecs.push_back('{"B_pos",   32'h00208463, IMM_B, 32'h0000_0008, 1'b0});
        vecs.push_back('{"U_neg",   32'h800002B7, IMM_U, 32'h8000_0000, 1'b0});
        vecs.push_back('{"U_pos",   32'h12345037, IMM_U, 32'h1234_5000, 1'b0});
        vecs.push_back('{"J_neg",   32'h800000EF, IMM_J, 32'hFFF0_0000, 1'b0});
        vecs.push_back('{"J_pos",   32'h0080006F, IMM_J, 32'h0000_0008, 1'b0});
        vecs.push_back('{"Z_csr",   32'h000FD073, IMM_Z, Z_IMM,         Z_ILL});
        vecs.push_back('{"ill_110", 32'hFFF00093, 3'b110, 32'h0,        1'b1});
        vecs.push_back('{"ill_111", 32'h800002B7, 3'b111, 32'h0,        1'b1});

        rst = 1'b1; bus64 = '0; ld_ir = 1'b0; imm_sel = IMM_I; en_imm = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        en_imm = 1'b1;
        step();
        chk("reset imm", imm64, 64'h0);
        chk("reset imm32", {32'h0, imm32}, 64'h0);
        chk("reset ir", {32'h0, ir32}, 64'h0);
        chk("reset flags", {valid32, drive32, ill32, valid64, drive64, ill64}, 64'h0);
        en_imm = 1'b0;

        foreach (vecs[i]) apply(vecs[i]);

        // Select change in READY: invalid on the mismatch cycle, then LOADED, then new value.
        load_ir(32'h00A12423, IMM_I);
        chk("selchg old", {32'h0, imm32}, 64'h0000_000A);
        imm_sel = IMM_S; en_imm = 1'b1;
        #1;
        chk("selchg valid_comb", {63'h0, valid32}, 64'h0);
        chk("selchg drive_drop", {63'h0, drive32}, 64'h0);
        step();
        chk("selchg valid_loaded", {63'h0, valid32}, 64'h0);
        step();
        chk("selchg valid", {63'h0, valid32}, 64'h1);
        chk("selchg imm", {32'h0, imm32}, 64'h0000_0008);
        chk("selchg drive", {63'h0, drive32}, 64'h1);

        // ld_ir with en_imm in READY: old immediate drives this cycle.
        bus64 = {32'h0, 32'hFFF00093}; ld_ir = 1'b1;
        #1;
        chk("ldrdy drive_old", {63'h0, drive32}, 64'h1);
        chk("ldrdy imm_old", {32'h0, imm32}, 64'h0000_0008);
        step();
        chk("ldrdy valid_drop", {62'h0, valid32, drive32}, 64'h0);
        chk("ldrdy ir", {32'h0, ir32}, 64'hFFF0_0093);
        ld_ir = 1'b0; en_imm = 1'b0;
        step();
        chk("ldrdy valid", {63'h0, valid32}, 64'h1);
        chk("ldrdy imm_new", {32'h0, imm32}, 64'hFFFF_FFE1);

        // IR holds without ld_ir.
        bus64 = 64'h1234_5678;
        step();
        chk("ir_hold", {32'h0, ir32}, 64'hFFF0_0093);
        chk("ir_hold valid", {63'h0, valid32}, 64'h1);

        // Back-to-back loads: latest word wins.
        bus64 = {32'h0, 32'h800000EF}; imm_sel = IMM_J; ld_ir = 1'b1;
        step();
        bus64 = {32'h0, 32'h0080006F};
        step();
        chk("reload valid", {63'h0, valid32}, 64'h0);
        chk("reload ir", {32'h0, ir32}, 64'h0080_006F);
        ld_ir = 1'b0;
        step();
        chk("reload imm", {32'h0, imm32}, 64'h0000_0008);
        chk("reload imm64", imm64, 64'h8);

        // Asynchronous reset in LOADED clears everything at once.
        bus64 = {32'h0, 32'hFFF00093}; imm_sel = IMM_I; ld_ir = 1'b1;
        step();
        ld_ir = 1'b0; en_imm = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("arst imm", {32'h0, imm32}, 64'h0);
        chk("arst imm64", imm64, 64'h0);
        chk("arst ir", {32'h0, ir32}, 64'h0);
        chk("arst flags", {valid32, drive32, ill32, valid64, drive64, ill64}, 64'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        step();
        chk("arst stays_empty", {62'h0, valid32, drive32}, 64'h0);
        en_imm = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
